// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : ARM instruction fetch stage. Owns the PC, runs a req/ack fetch
//            port and holds the fetched word plus decode fields until retired.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic [31:0] pc_target,
  output logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8,
  output logic [31:0] instr_count
);

  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic [31:0] pc_branch;
  logic        capture;
  logic        retire;
  logic        unused_target_lsbs;

  // Branch targets are forced to word alignment; the low bits are dropped.
  assign pc_branch          = {pc_target[31:2], 2'b00};
  assign pc_seq             = pc_out + PC_INC;
  assign unused_target_lsbs = ^pc_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    retire      = 1'b0;
    case (state)
      ST_RST: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'h0000_0000;
      pc_out      <= RESET_PC;
      instr_count <= 32'h0000_0000;
    end else begin
      if (capture) begin
        instr  <= imem_rdata;
        pc_out <= pc;
      end
      if (retire) begin
        instr_count <= instr_count + 32'd1;
        pc          <= pcsrc ? pc_branch : pc_seq;
      end
    end
  end

  assign imem_addr = pc;
  assign cond      = instr[31:28];
  assign op        = instr[27:26];
  assign funct     = instr[25:20];
  assign rd        = instr[15:12];
  assign pc_plus8  = pc_out + 32'd8;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit: expected fetches and retirements
//            are queued by the stimulus and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic [31:0] pc_target;
  logic [31:0] instr;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;
  logic [31:0] instr_count;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pcsrc       (pcsrc),
    .pc_target   (pc_target),
    .instr       (instr),
    .cond        (cond),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .pc_out      (pc_out),
    .pc_plus8    (pc_plus8),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after ack_delay waiting cycles; ack_force drives ack regardless.
  int   ack_delay;
  int   wait_cnt;
  logic ack_force;

  assign imem_ack = ack_force | (imem_req && (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
  end

  always_comb begin
    case (imem_addr)
      32'h0000_0040: imem_rdata = 32'hE3A0_D0FF;
      32'hFFFF_FFFC: imem_rdata = 32'h5A4B_3C2D;
      default:       imem_rdata = 32'hE081_0002;
    endcase
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [3:0]  cnd;
    logic [1:0]  o;
    logic [5:0]  f;
    logic [3:0]  r;
    logic [31:0] p8;
    logic [31:0] cnt;
  } ret_t;

  logic [31:0] fetch_q[$];
  ret_t        ret_q[$];
  int          compared;
  int          mismatched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ret(input logic [31:0] pc, input logic [31:0] ins, input logic [3:0] cnd,
                          input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                          input logic [31:0] p8, input logic [31:0] cnt);
    ret_t e;
    e.pc = pc; e.ins = ins; e.cnd = cnd; e.o = o; e.f = f; e.r = r; e.p8 = p8; e.cnt = cnt;
    ret_q.push_back(e);
  endtask

  // Monitor: every accepted fetch and every retirement is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ack) begin
        if (fetch_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, fetch_q.pop_front());
        end
      end
      if (instr_valid && instr_ready) begin
        if (ret_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL retire_unexpected: got pc %h expected no retire", pc_out);
        end else begin
          ret_t e;
          e = ret_q.pop_front();
          check("ret_pc",    pc_out,         e.pc);
          check("ret_instr", instr,          e.ins);
          check("ret_cond",  {28'd0, cond},  {28'd0, e.cnd});
          check("ret_op",    {30'd0, op},    {30'd0, e.o});
          check("ret_funct", {26'd0, funct}, {26'd0, e.f});
          check("ret_rd",    {28'd0, rd},    {28'd0, e.r});
          check("ret_pc8",   pc_plus8,       e.p8);
          check("ret_count", instr_count,    e.cnt);
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_req"},   {31'd0, imem_req},    32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr,                32'd0);
    check({tag, "_cond"},  {28'd0, cond},        32'd0);
    check({tag, "_count"}, instr_count,          32'd0);
    check({tag, "_addr"},  imem_addr,            32'd0);
  endtask

  task automatic wait_hold(input logic [31:0] pc, input int maxc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      @(posedge clk);
      #1;
      if (instr_valid && pc_out == pc) found = 1'b1;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL wait_hold: got timeout after %0d cycles expected hold at %h", maxc, pc);
    end
  endtask

  task automatic wait_fetch(input logic [31:0] addr, input int maxc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      @(posedge clk);
      #1;
      if (imem_req && imem_addr == addr) found = 1'b1;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL wait_fetch: got timeout after %0d cycles expected fetch at %h", maxc, addr);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    ack_force   = 1'b1;   // an ack during reset must be ignored
    ack_delay   = 0;
    instr_ready = 1'b1;
    pcsrc       = 1'b0;
    pc_target   = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("rst");
    ack_force = 1'b0;

    // Zero-wait fetches, ready tied high, then two branches (aligned and unaligned target).
    fetch_q.push_back(32'h0000_0000);
    fetch_q.push_back(32'h0000_0004);
    fetch_q.push_back(32'h0000_0008);
    fetch_q.push_back(32'h0000_0040);
    fetch_q.push_back(32'h0000_0040);
    fetch_q.push_back(32'h0000_0004);
    push_ret(32'h0, 32'hE081_0002, 4'hE, 2'd0, 6'h08, 4'h0, 32'h08, 32'd0);
    push_ret(32'h4, 32'hE081_0002, 4'hE, 2'd0, 6'h08, 4'h0, 32'h0C, 32'd1);
    push_ret(32'h8, 32'hE081_0002, 4'hE, 2'd0, 6'h08, 4'h0, 32'h10, 32'd2);
    push_ret(32'h40, 32'hE3A0_D0FF, 4'hE, 2'd0, 6'h3A, 4'hD, 32'h48, 32'd3);
    push_ret(32'h40, 32'hE3A0_D0FF, 4'hE, 2'd0, 6'h3A, 4'hD, 32'h48, 32'd4);
    push_ret(32'h4, 32'hE081_0002, 4'hE, 2'd0, 6'h08, 4'h0, 32'h0C, 32'd5);
    @(negedge clk);
    #2 rst_n = 1'b1;

    wait_hold(32'h8, 20);
    pcsrc     = 1'b1;
    pc_target = 32'h0000_0040;
    wait_hold(32'h40, 20);
    pc_target = 32'h0000_0043;
    wait_hold(32'h40, 20);

    // Stall in HOLD with pcsrc toggling: nothing may move.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pcsrc     = ~pcsrc;
      pc_target = 32'h100 + 32'(i * 4);
      @(negedge clk);
      check("stall_req",   {31'd0, imem_req},    32'd0);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_count", instr_count,          32'd4);
      @(posedge clk);
      #1;
    end
    check("stall_instr", instr,  32'hE3A0_D0FF);
    check("stall_pc",    pc_out, 32'h40);

    // Branch to 0x4 with a 3-cycle ack delay there.
    pcsrc       = 1'b1;
    pc_target   = 32'h0000_0004;
    ack_delay   = 3;
    instr_ready = 1'b1;
    wait_fetch(32'h4, 10);
    pcsrc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wait_req",   {31'd0, imem_req},    32'd1);
      check("wait_addr",  imem_addr,            32'h4);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    @(negedge clk);
    check("ack_valid", {31'd0, instr_valid}, 32'd1);

    // Reset asserted mid-fetch at 0x8 takes effect without a clock edge.
    wait_fetch(32'h8, 10);
    @(negedge clk);
    #1 rst_n = 1'b0;
    ack_force = 1'b1;
    #1;
    check_reset("midrst");
    @(posedge clk);
    @(negedge clk);
    ack_force = 1'b0;
    ack_delay = 0;

    // Restart at RESET_PC, then branch to the top word and wrap sequentially to 0.
    fetch_q.push_back(32'h0000_0000);
    fetch_q.push_back(32'hFFFF_FFFC);
    fetch_q.push_back(32'h0000_0000);
    push_ret(32'h0, 32'hE081_0002, 4'hE, 2'd0, 6'h08, 4'h0, 32'h08, 32'd0);
    push_ret(32'hFFFF_FFFC, 32'h5A4B_3C2D, 4'h5, 2'd2, 6'h24, 4'h3, 32'h04, 32'd1);
    #2 rst_n = 1'b1;
    wait_hold(32'h0, 20);
    pcsrc     = 1'b1;
    pc_target = 32'hFFFF_FFFF;
    wait_fetch(32'hFFFF_FFFC, 10);
    pcsrc = 1'b0;
    wait_hold(32'h0, 20);
    instr_ready = 1'b0;
    @(negedge clk);
    check("final_count", instr_count, 32'd2);
    check("fetch_q_left", fetch_q.size(), 32'd0);
    check("ret_q_left",   ret_q.size(),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
